// File: rtl/vga_sync_decoder.sv
// Sync-pin decoder: recovers pixel strobe, active-area coordinates and mode lock from hsync/vsync.
// Optional input synchronizer for asynchronous syncs: define VGA_SYNC_DECODER_SYNC_EN.
module vga_sync_decoder #(
  parameter int CLK_MHZ     = 100,
  parameter int PIXEL_MHZ   = 25,
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic        pixel_tick,
  output logic        display_on,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        err
);

  localparam int DIV = CLK_MHZ / PIXEL_MHZ;
  localparam int DW  = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [DW-1:0] DIV_ZERO  = {DW{1'b0}};
  localparam logic [10:0]   CNT_MAX   = 11'd2047;
  localparam logic [10:0]   H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0]   V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0]   TIMEOUT_C = 11'(2 * H_TOTAL);
  localparam logic [10:0]   HS_C      = 11'(H_SYNC + H_BACK);
  localparam logic [10:0]   HE_C      = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0]   VS_C      = 11'(V_SYNC + V_BACK);
  localparam logic [10:0]   VE_C      = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]    HS_P      = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]    VS_P      = 10'(V_SYNC + V_BACK);
  localparam logic [1:0]    LOCK_C    = 2'(LOCK_FRAMES);
  localparam logic          POL       = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic hs_in_s, vs_in_s;

`ifdef VGA_SYNC_DECODER_SYNC_EN
  logic [1:0] hs_sync_q, vs_sync_q;

  // two-flop synchronizer ahead of edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sync_q <= {2{~POL}};
      vs_sync_q <= {2{~POL}};
    end else begin
      hs_sync_q <= {hs_sync_q[0], hsync};
      vs_sync_q <= {vs_sync_q[0], vsync};
    end
  end

  assign hs_in_s = hs_sync_q[1];
  assign vs_in_s = vs_sync_q[1];
`else
  assign hs_in_s = hsync;
  assign vs_in_s = vsync;
`endif

  logic          hs_q, hs_q2, vs_q, vs_q2;
  logic          hs_edge_s, vs_edge_s;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q;
  logic [10:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0]   hcnt_inc_s, vcnt_inc_s;
  logic [10:0]   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic          h_act_s, v_act_s;
  logic [9:0]    hpos_q, vpos_q;
  logic          disp_q;
  logic          line_bad_s, frame_bad_s, timeout_s;
  state_t        state_q;
  logic [1:0]    good_q;
  logic          first_q;
  logic          locked_q, err_q;

  // edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= ~POL;
      hs_q2 <= ~POL;
      vs_q  <= ~POL;
      vs_q2 <= ~POL;
    end else begin
      hs_q  <= hs_in_s;
      hs_q2 <= hs_q;
      vs_q  <= vs_in_s;
      vs_q2 <= vs_q;
    end
  end

  assign hs_edge_s = (hs_q == POL) && (hs_q2 != POL);
  assign vs_edge_s = (vs_q == POL) && (vs_q2 != POL);

  assign hcnt_inc_s = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
  assign vcnt_inc_s = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 11'd1;

  // divider and counter next-state; a vsync edge overrides a coincident hsync edge for vcnt
  always_comb begin
    div_d         = div_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (hs_edge_s) begin
      div_d      = DIV_ONE;
      hcnt_d     = 11'd0;
      line_len_d = hcnt_inc_s;
    end else begin
      div_d  = (div_q == DIV_LAST) ? DIV_ZERO : div_q + DIV_ONE;
      hcnt_d = tick_q ? hcnt_inc_s : hcnt_q;
    end
    if (vs_edge_s) begin
      vcnt_d        = 11'd0;
      frame_lines_d = vcnt_inc_s;
    end else if (hs_edge_s) begin
      vcnt_d = vcnt_inc_s;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  assign h_act_s     = (hcnt_d >= HS_C) && (hcnt_d < HE_C);
  assign v_act_s     = (vcnt_d >= VS_C) && (vcnt_d < VE_C);
  assign line_bad_s  = hs_edge_s && (hcnt_inc_s != H_TOTAL_C);
  assign frame_bad_s = vs_edge_s && (vcnt_inc_s != V_TOTAL_C);
  assign timeout_s   = (hcnt_d == TIMEOUT_C) && (hcnt_q != TIMEOUT_C);

  // counters and coordinate outputs; lock only changes where the next position lies outside
  // the active window, so gating with the current lock flag matches the post-edge lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= DIV_ZERO;
      tick_q        <= 1'b0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 11'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 11'd0;
      disp_q        <= 1'b0;
      hpos_q        <= 10'd0;
      vpos_q        <= 10'd0;
    end else begin
      div_q         <= div_d;
      tick_q        <= (div_d == DIV_ZERO);
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      disp_q        <= locked_q && h_act_s && v_act_s;
      hpos_q        <= (locked_q && h_act_s && v_act_s) ? (hcnt_d[9:0] - HS_P) : 10'd0;
      vpos_q        <= (locked_q && h_act_s && v_act_s) ? (vcnt_d[9:0] - VS_P) : 10'd0;
    end
  end

  // lock state machine with registered locked/err flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      good_q   <= 2'd0;
      first_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (timeout_s) begin
        state_q  <= ST_SEARCH;
        locked_q <= 1'b0;
        err_q    <= (state_q != ST_SEARCH);
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (vs_edge_s) begin
              state_q <= ST_MEASURE;
              good_q  <= 2'd0;
              first_q <= 1'b1;
            end
          end
          ST_MEASURE: begin
            if ((line_bad_s && !first_q) || frame_bad_s) begin
              state_q <= ST_SEARCH;
              err_q   <= 1'b1;
            end else if (vs_edge_s) begin
              good_q <= good_q + 2'd1;
              if ((good_q + 2'd1) == LOCK_C) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end
            if (hs_edge_s) begin
              first_q <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (line_bad_s || frame_bad_s) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pixel_tick  = tick_q;
  assign display_on  = disp_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
